// File: rtl/tx_pri_queue_status_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_pri_queue_status_pkg
//  Description : Shared defaults and FSM encoding for the TX priority queue
//                status block.
//  Revision    : 1.0 - initial release
// ============================================================================
package tx_pri_queue_status_pkg;

  localparam int PORT_FIFO_PRI_NUM_DEF = 8;
  localparam int CNT_W_DEF             = 8;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_SENDING = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tx_pri_queue_status_if.sv
`default_nettype none
// ============================================================================
//  Module      : tx_pri_queue_status_if
//  Description : Enqueue / scheduler handshake bundle for the TX queue status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tx_pri_queue_status_if
  import tx_pri_queue_status_pkg::*;
#(
  parameter int PORT_FIFO_PRI_NUM = PORT_FIFO_PRI_NUM_DEF,
  parameter int PRI_W             = $clog2(PORT_FIFO_PRI_NUM)
);

  logic                         i_enq_vld;
  logic [PRI_W-1:0]             i_enq_pri;
  logic [PORT_FIFO_PRI_NUM-1:0] i_fifo_pri_rd_en;
  logic                         i_tx_frame_done;
  logic [PORT_FIFO_PRI_NUM-1:0] o_tx_mac_forward_info;
  logic                         o_tx_mac_forward_info_vld;

  // master: fabric/scheduler/MAC side, slave: the status block
  modport master (
    output i_enq_vld, i_enq_pri, i_fifo_pri_rd_en, i_tx_frame_done,
    input  o_tx_mac_forward_info, o_tx_mac_forward_info_vld
  );

  modport slave (
    input  i_enq_vld, i_enq_pri, i_fifo_pri_rd_en, i_tx_frame_done,
    output o_tx_mac_forward_info, o_tx_mac_forward_info_vld
  );

endinterface
`default_nettype wire

// File: rtl/tx_pri_queue_status_frame_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : tx_pri_frame_cnt
//  Description : Saturating up/down frame counter for one priority FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_pri_frame_cnt
  import tx_pri_queue_status_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst,
  input  wire logic             i_inc,
  input  wire logic             i_dec,
  output logic [CNT_W-1:0]      o_cnt,
  output logic [CNT_W-1:0]      o_cnt_nxt,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam logic [CNT_W-1:0] c_max = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_overflow;
  logic             w_underflow;

  // inc and dec together net to zero, so neither can over/underflow
  assign w_overflow  = i_inc && !i_dec && (r_cnt == c_max);
  assign w_underflow = i_dec && !i_inc && (r_cnt == '0);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_inc && !i_dec && !w_overflow) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else if (i_dec && !i_inc && !w_underflow) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_cnt       = r_cnt;
  assign o_cnt_nxt   = w_cnt_nxt;
  assign o_overflow  = w_overflow;
  assign o_underflow = w_underflow;

endmodule
`default_nettype wire

// File: rtl/tx_pri_queue_status.sv
`default_nettype none
// ============================================================================
//  Module      : tx_pri_queue_status
//  Description : Per-priority frame occupancy, empty-vector strobe generation
//                and read-grant checking for the TX QoS scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_pri_queue_status
  import tx_pri_queue_status_pkg::*;
#(
  parameter int PORT_FIFO_PRI_NUM = PORT_FIFO_PRI_NUM_DEF,
  parameter int PRI_W             = $clog2(PORT_FIFO_PRI_NUM),
  parameter int CNT_W             = CNT_W_DEF
) (
  input  wire logic                           i_clk,
  input  wire logic                           i_rst,
  tx_pri_queue_status_if.slave                bus,
  input  wire logic                           i_err_clr,
  output logic                                o_tx_busy,
  output logic [PORT_FIFO_PRI_NUM*CNT_W-1:0]  o_pri_cnt,
  output logic                                o_err_overflow,
  output logic                                o_err_underflow,
  output logic                                o_err_grant
);

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0]             w_cnt     [PORT_FIFO_PRI_NUM];
  logic [CNT_W-1:0]             w_cnt_nxt [PORT_FIFO_PRI_NUM];
  logic [PORT_FIFO_PRI_NUM-1:0] w_inc;
  logic [PORT_FIFO_PRI_NUM-1:0] w_dec;
  logic [PORT_FIFO_PRI_NUM-1:0] w_cnt_ovf;
  logic [PORT_FIFO_PRI_NUM-1:0] w_cnt_unf;
  logic [PORT_FIFO_PRI_NUM-1:0] w_empty_cur;
  logic [PORT_FIFO_PRI_NUM-1:0] w_empty_nxt;
  logic [PORT_FIFO_PRI_NUM-1:0] w_rd_en;

  logic w_any_grant;
  logic w_sel_nonzero;
  logic w_err_grant_set;
  logic w_err_unf_set;
  logic w_err_ovf_set;

  logic [PORT_FIFO_PRI_NUM-1:0] r_info;
  logic                         r_info_vld;
  logic                         r_boot;
  logic                         r_err_overflow;
  logic                         r_err_underflow;
  logic                         r_err_grant;

  assign w_rd_en = bus.i_fifo_pri_rd_en;

  generate
    for (genvar p = 0; p < PORT_FIFO_PRI_NUM; p++) begin : g_pri
      assign w_inc[p] = bus.i_enq_vld && (bus.i_enq_pri == PRI_W'(p));

      tx_pri_frame_cnt #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_inc       (w_inc[p]),
        .i_dec       (w_dec[p]),
        .o_cnt       (w_cnt[p]),
        .o_cnt_nxt   (w_cnt_nxt[p]),
        .o_overflow  (w_cnt_ovf[p]),
        .o_underflow (w_cnt_unf[p])
      );

      assign w_empty_cur[p]              = (w_cnt[p] == '0);
      assign w_empty_nxt[p]              = (w_cnt_nxt[p] == '0);
      assign o_pri_cnt[p*CNT_W +: CNT_W] = w_cnt[p];
    end
  endgenerate

  assign w_any_grant   = |w_rd_en;
  assign w_sel_nonzero = |(w_rd_en & ~w_empty_cur);
  assign w_err_ovf_set = |w_cnt_ovf;

  always_comb begin
    w_state_nxt     = r_state;
    w_dec           = '0;
    w_err_grant_set = 1'b0;
    w_err_unf_set   = |w_cnt_unf;
    case (r_state)
      ST_IDLE: begin
        if (w_any_grant) begin
          if (!$onehot(w_rd_en)) begin
            w_err_grant_set = 1'b1;
          end else if (!w_sel_nonzero) begin
            w_err_unf_set = 1'b1;
          end else begin
            w_dec       = w_rd_en;
            w_state_nxt = ST_SENDING;
          end
        end
      end
      ST_SENDING: begin
        if (w_any_grant) begin
          w_err_grant_set = 1'b1;
        end
        if (bus.i_tx_frame_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The published empty vector only moves while the scheduler may act on it;
  // changes made during SENDING are released together with the return strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_info     <= '1;
      r_info_vld <= 1'b0;
      r_boot     <= 1'b1;
    end else begin
      r_boot     <= 1'b0;
      r_info_vld <= (w_state_nxt == ST_IDLE) &&
                    (r_boot || (w_empty_nxt != r_info) || (r_state == ST_SENDING));
      if (w_state_nxt == ST_IDLE) begin
        r_info <= w_empty_nxt;
      end
    end
  end

  // a fresh error event wins over a coincident clear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
      r_err_grant     <= 1'b0;
    end else begin
      r_err_overflow  <= w_err_ovf_set   || (r_err_overflow  && !i_err_clr);
      r_err_underflow <= w_err_unf_set   || (r_err_underflow && !i_err_clr);
      r_err_grant     <= w_err_grant_set || (r_err_grant     && !i_err_clr);
    end
  end

  assign bus.o_tx_mac_forward_info     = r_info;
  assign bus.o_tx_mac_forward_info_vld = r_info_vld;
  assign o_tx_busy                     = (r_state == ST_SENDING);
  assign o_err_overflow                = r_err_overflow;
  assign o_err_underflow               = r_err_underflow;
  assign o_err_grant                   = r_err_grant;

endmodule
`default_nettype wire
